// File: rtl/traceback_ctrl.sv
// Viterbi traceback sequencer: tracks survivor-memory fill, runs seed/trace bursts, returns bytes.
// Optional byte counter output o_byte_cnt enabled by defining TB_CTRL_STATS_EN.
module traceback_ctrl #(
  parameter int unsigned MAX_STATE_REG_NUM = 8,
  parameter int unsigned MEM_DEPTH         = 64,
  parameter int unsigned ADDR_W            = 6,
  parameter int unsigned TB_DEPTH          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        i_constr_len,
  input  logic              i_start,
  input  logic              i_acs_valid,
  input  logic              i_acs_last,
  input  logic [7:0]        i_decoder_data,
  output logic              o_en_t,
  output logic              o_ood,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_rd_addr,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [7:0]        o_byte,
  output logic              o_busy,
  output logic              o_overflow
`ifdef TB_CTRL_STATS_EN
  ,
  output logic [15:0]       o_byte_cnt
`endif
);

  localparam int unsigned FW  = ADDR_W + 1;
  localparam int unsigned FSW = FW + 1;
  localparam logic [FW-1:0]  DEPTH_F = FW'(MEM_DEPTH);
  localparam logic [FW-1:0]  TBD_F   = FW'(TB_DEPTH);
  localparam logic [FW-1:0]  FOUR_F  = FW'(4);
  localparam logic [FSW-1:0] FOUR_S  = FSW'(4);

  if (MAX_STATE_REG_NUM == 0 || MEM_DEPTH != (1 << ADDR_W) ||
      TB_DEPTH < 4 || TB_DEPTH > MEM_DEPTH) begin : g_param_check
    $error("traceback_ctrl: inconsistent parameters");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SEED,
    S_TRACE,
    S_OUT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [FSW-1:0]    fill_sum;
  logic [1:0]        tcnt_q, tcnt_d;
  logic              last_q, last_d;
  logic              ovf_q, ovf_d;
  logic [1:0]        clen_q, clen_d;
  logic [7:0]        byte_q, byte_d;
  logic              wr_seen, wr_acc, full, hs, start_acc;

  // Column bookkeeping runs in every non-IDLE state, independent of the sequencer.
  always_comb begin
    start_acc = (state_q == S_IDLE) && i_start;
    wr_seen   = i_acs_valid && (state_q != S_IDLE);
    full      = (fill_q == DEPTH_F);
    wr_acc    = wr_seen && !full;
    hs        = (state_q == S_OUT) && i_out_ready;

    fill_sum = {1'b0, fill_q} + {{FW{1'b0}}, wr_acc};
    fill_d   = fill_sum[FW-1:0];
    if (hs) begin
      fill_d = (fill_sum > FOUR_S) ? FW'(fill_sum - FOUR_S) : '0;
    end

    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    ovf_d    = ovf_q | (wr_seen && full);

    last_d = last_q;
    if (start_acc) begin
      last_d = 1'b0;
    end else if (wr_seen && i_acs_last) begin
      last_d = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    tcnt_d      = tcnt_q;
    byte_d      = byte_q;
    clen_d      = clen_q;
    o_en_t      = 1'b0;
    o_mem_rd_en = 1'b0;
    o_ood       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_FILL;
          clen_d  = i_constr_len;
        end
      end
      S_FILL: begin
        if (fill_q >= TBD_F || (last_q && fill_q != '0)) begin
          state_d  = S_SEED;
          rd_ptr_d = wr_ptr_q - 1'b1;
        end
      end
      S_SEED: begin
        o_mem_rd_en = 1'b1;
        tcnt_d      = '0;
        state_d     = S_TRACE;
      end
      S_TRACE: begin
        o_en_t      = 1'b1;
        o_mem_rd_en = 1'b1;
        rd_ptr_d    = rd_ptr_q - 1'b1;
        tcnt_d      = tcnt_q + 1'b1;
        if (tcnt_q == 2'd3) begin
          o_ood   = last_q && (fill_q <= FOUR_F);
          byte_d  = i_decoder_data;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (hs) begin
          state_d = (last_q && fill_d == '0) ? S_IDLE : S_FILL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      tcnt_q   <= '0;
      last_q   <= 1'b0;
      ovf_q    <= 1'b0;
      clen_q   <= '0;
      byte_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      tcnt_q   <= tcnt_d;
      last_q   <= last_d;
      ovf_q    <= ovf_d;
      clen_q   <= clen_d;
      byte_q   <= byte_d;
    end
  end

  always_comb begin
    o_mem_rd_addr = rd_ptr_q;
    o_out_valid   = (state_q == S_OUT);
    o_byte        = byte_q;
    o_busy        = (state_q != S_IDLE);
    o_overflow    = ovf_q;
  end

`ifdef TB_CTRL_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_acc) begin
      cnt_d = '0;
    end else if (hs) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_byte_cnt = cnt_q;
`endif

endmodule
